seq_shift_unit: RTL and testbench

- Multi-cycle iterative shifter for the RV32I ALU path, shifting STEP bits per cycle.
- Covers SLL, SRL and SRA (the right-shift direction uses correct encodings) behind a valid/ready handshake.
- Replaces the single-cycle barrel path when timing or area requires it; sits between ID/EX operand registers and the EX result mux.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/seq_shift_unit_step.sv | 28 ++
 rtl/seq_shift_unit.sv | 84 ++++++++
 tb/tb_seq_shift_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and types for the iterative shifter.
// Imported by the shift datapath and its control FSM.
package shift_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] op_t;

  localparam op_t SH_SLL  = 2'b00;
  localparam op_t SH_SRL  = 2'b01;
  localparam op_t SH_SRA  = 2'b10;
  localparam op_t SH_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/seq_shift_unit_step.sv
// One iteration of the shifter: shifts acc by k (k <= STEP).
// Only STEP+1 constant shifts exist, so the mux stays narrow.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [4:0]      k_i,
  input  op_t             op_i,
  output logic [XLEN-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int j = 1; j <= STEP; j++) begin
      if (k_i == 5'(j)) begin
        unique case (1'b1)
          (op_i == SH_SLL): acc_o = acc_i << j;
          (op_i == SH_SRL): acc_o = acc_i >> j;
          (op_i == SH_SRA): acc_o = $signed(acc_i) >>> j;
          default:          acc_o = acc_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit, STEP bits per cycle.
// Valid/ready on both sides; outputs decode from registered state.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [4:0]      shamt_i,
  input  logic [1:0]      type_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] r_o
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t          state_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] r_q;
  logic [4:0]      cnt_q;
  logic [4:0]      k;
  op_t             op_q;

  assign k = (cnt_q < STEP_K) ? cnt_q : STEP_K;

  shift_step #(
    .STEP(STEP)
  ) u_step (
    .acc_i(acc_q),
    .k_i  (k),
    .op_i (op_q),
    .acc_o(acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            acc_q <= a_i;
            op_q  <= type_i;
            if (shamt_i == 5'd0 || type_i == SH_PASS) begin
              cnt_q   <= '0;
              r_q     <= a_i;
              state_q <= DONE;
            end else begin
              cnt_q   <= shamt_i;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - k;
          if (cnt_q == k) begin
            r_q     <= acc_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign r_o         = r_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: STEP=1 and STEP=4 instances,
// directed cases then random ops against an arithmetic model.
module tb_seq_shift_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] a    [2];
  logic [31:0] r    [2];
  logic [4:0]  sh   [2];
  logic [1:0]  ty   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.STEP(1)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (iv[0]),
    .in_ready_o (ir[0]),
    .a_i        (a[0]),
    .shamt_i    (sh[0]),
    .type_i     (ty[0]),
    .out_valid_o(ov[0]),
    .out_ready_i(ordy[0]),
    .r_o        (r[0])
  );

  seq_shift_unit #(.STEP(4)) u_s4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (iv[1]),
    .in_ready_o (ir[1]),
    .a_i        (a[1]),
    .shamt_i    (sh[1]),
    .type_i     (ty[1]),
    .out_valid_o(ov[1]),
    .out_ready_i(ordy[1]),
    .r_o        (r[1])
  );

  function automatic int step_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] model(logic [31:0] x, int s, logic [1:0] op);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case (op)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return (x >> s) | (x[31] ? ~(ones >> s) : 32'h0);
      default: return x;
    endcase
  endfunction

  function automatic int model_lat(int s, logic [1:0] op, int step);
    if (s == 0 || op == 2'b11) return 1;
    return 1 + (s + step - 1) / step;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic run(int d, logic [31:0] av, int s, logic [1:0] op,
                     int hold, string tag);
    logic [31:0] exp;
    int el;
    int n;
    exp = model(av, s, op);
    el  = model_lat(s, op, step_of(d));
    n   = 0;
    chk({tag, "_in_ready"}, 32'(ir[d]), 32'd1);
    iv[d]   = 1'b1;
    a[d]    = av;
    sh[d]   = s[4:0];
    ty[d]   = op;
    ordy[d] = (hold == 0);
    do begin
      @(posedge clk);
      #1;
      n++;
      iv[d] = 1'b0;
      a[d]  = $urandom;
      sh[d] = 5'($urandom);
      ty[d] = 2'($urandom);
    end while (!ov[d] && n < 200);
    chk({tag, "_latency"}, 32'(n), 32'(el));
    chk({tag, "_r"}, r[d], exp);
    for (int i = 0; i < hold; i++) begin
      iv[d] = 1'b1;
      a[d]  = $urandom;
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(ov[d]), 32'd1);
      chk({tag, "_hold_r"}, r[d], exp);
      chk({tag, "_hold_ready"}, 32'(ir[d]), 32'd0);
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(ov[d]), 32'd0);
    chk({tag, "_ready_back"}, 32'(ir[d]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      a[d]    = '0;
      sh[d]   = '0;
      ty[d]   = '0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_r", r[d], 32'h0);
      chk("rst_valid", 32'(ov[d]), 32'd0);
      chk("rst_ready", 32'(ir[d]), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(0, 32'h0000_0001, 31, SH_SLL, 0, "sll31");
    run(0, 32'h8000_0000, 4, SH_SRA, 0, "sra_neg");
    run(0, 32'h8000_0000, 4, SH_SRL, 0, "srl_msb");
    run(0, 32'h7FFF_FFF0, 4, SH_SRA, 0, "sra_pos");
    run(0, 32'hDEAD_BEEF, 0, SH_SRA, 0, "sh0");
    run(0, 32'hDEAD_BEEF, 7, SH_PASS, 0, "pass");
    run(1, 32'h0000_00FF, 5, SH_SLL, 0, "s4_sll5");
    run(1, 32'h8000_0001, 31, SH_SRA, 0, "s4_sra31");
    run(1, 32'h1234_5678, 8, SH_SRL, 3, "s4_bp");
    run(0, 32'hCAFE_F00D, 3, SH_SLL, 3, "s1_bp");

    iv[0] = 1'b1;
    a[0]  = 32'hFFFF_0000;
    sh[0] = 5'd20;
    ty[0] = SH_SRL;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov[0]), 32'd0);
    chk("arst_r", r[0], 32'h0);
    chk("arst_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_hold_valid", 32'(ov[0]), 32'd0);
    run(0, 32'hF000_0000, 28, SH_SRL, 0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      run(i % 2, $urandom, int'($urandom_range(0, 31)),
          2'($urandom), int'($urandom_range(0, 2)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
